// File: rtl/de1soc_io_pkg.sv
// Shared types and default timing for the DE1-SoC switch/button conditioner.
package de1soc_io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } key_state_t;

  localparam int CLK_HZ           = 50_000_000;
  localparam int DEBOUNCE_MS      = 10;
  localparam int REPEAT_DELAY_MS  = 500;
  localparam int REPEAT_PERIOD_MS = 100;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEF_DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS);
  localparam int DEF_REPEAT_DELAY    = ms_to_cycles(REPEAT_DELAY_MS);
  localparam int DEF_REPEAT_PERIOD   = ms_to_cycles(REPEAT_PERIOD_MS);

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser plus candidate/counter debounce for a W-bit group.
// The whole group is accepted at once, with a one-cycle change strobe.
module input_debounce #(
  parameter int             W               = 1,
  parameter int             DEBOUNCE_CYCLES = 500000,
  parameter logic [W-1:0]   RESET_VAL       = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable,
  output logic         changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("input_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [W-1:0]     sync_q1;
  logic [W-1:0]     sync_q2;
  logic [W-1:0]     cand;
  logic [CNT_W-1:0] cnt;

  // Synchroniser resets to the idle pin level so reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= RESET_VAL;
      sync_q2 <= RESET_VAL;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand    <= RESET_VAL;
      cnt     <= '0;
      stable  <= RESET_VAL;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (sync_q2 != cand) begin
        cand <= sync_q2;
        cnt  <= '0;
      end else if (cand != stable) begin
        if (cnt == CNT_LAST) begin
          stable  <= cand;
          cnt     <= '0;
          changed <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/de1soc_input_conditioner.sv
// Conditions DE1-SoC slide switches and KEY_N[2:0]: debounced levels,
// press/release strobes and per-key auto-repeat.
import de1soc_io_pkg::*;

module de1soc_input_conditioner #(
  parameter int N_SW            = 10,
  parameter int N_KEY           = 3,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  sw_async,
  input  logic [N_KEY-1:0] key_n_async,
  output logic [N_SW-1:0]  sw_stable,
  output logic             sw_changed,
  output logic [N_KEY-1:0] key_level,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_KEY-1:0] key_repeat
);

  localparam int RCNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W   = $clog2(RCNT_MAX);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
    $error("de1soc_input_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
  end

  input_debounce #(
    .W               (N_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       ({N_SW{1'b0}})
  ) u_sw_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (sw_async),
    .stable  (sw_stable),
    .changed (sw_changed)
  );

  for (genvar k = 0; k < N_KEY; k++) begin : g_key
    // state  | meaning
    // IDLE   | key released, waiting for a debounced press
    // HOLD   | key held, counting down the initial repeat delay
    // REPEAT | key held, emitting a repeat strobe every REPEAT_PERIOD cycles
    key_state_t        state;
    key_state_t        state_nxt;
    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] rcnt_nxt;
    logic              stable_n;
    logic              chg;
    logic              level;
    logic              rise;
    logic              fall;
    logic              press;
    logic              release_s;
    logic              repeat_s;

    // Debounce runs on the raw active-low pin; inversion happens on the stable level.
    input_debounce #(
      .W               (1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
    ) u_key_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (key_n_async[k]),
      .stable  (stable_n),
      .changed (chg)
    );

    assign level = ~stable_n;
    assign rise  = chg & level;
    assign fall  = chg & ~level;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      case (state)
        IDLE: begin
          rcnt_nxt = '0;
          if (rise) state_nxt = HOLD;
        end
        HOLD: begin
          if (fall) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == DELAY_LAST) begin
            state_nxt = REPEAT;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        REPEAT: begin
          if (fall) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == PERIOD_LAST) begin
            rcnt_nxt = '0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end

    // A release in the same cycle as a due repeat suppresses the repeat.
    always_comb begin
      press     = (state == IDLE) && rise;
      release_s = (state != IDLE) && fall;
      repeat_s  = !fall && (((state == HOLD) && (rcnt == DELAY_LAST)) ||
                            ((state == REPEAT) && (rcnt == PERIOD_LAST)));
    end

    assign key_level[k]   = level;
    assign key_press[k]   = press;
    assign key_release[k] = release_s;
    assign key_repeat[k]  = repeat_s;
  end

endmodule

// File: tb/tb_de1soc_input_conditioner.sv
// Self-checking bench: expected strobe events are queued when stimulus is applied
// and matched, edge-accurately, against every strobe the DUT emits.
module tb_de1soc_input_conditioner;

  localparam int N_SW  = 10;
  localparam int N_KEY = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_SW-1:0]  sw_async;
  logic [N_KEY-1:0] key_n_async;
  logic [N_SW-1:0]  sw_stable;
  logic             sw_changed;
  logic [N_KEY-1:0] key_level;
  logic [N_KEY-1:0] key_press;
  logic [N_KEY-1:0] key_release;
  logic [N_KEY-1:0] key_repeat;

  de1soc_input_conditioner #(
    .N_SW            (N_SW),
    .N_KEY           (N_KEY),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_async    (sw_async),
    .key_n_async (key_n_async),
    .sw_stable   (sw_stable),
    .sw_changed  (sw_changed),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         rel;
    logic       sw_chg;
    logic [9:0] sw;
    logic [2:0] lvl;
    logic [2:0] press;
    logic [2:0] rls;
    logic [2:0] rpt;
  } ev_t;

  typedef struct packed {
    logic [9:0] sw_in;
    logic [9:0] sw_exp;
  } sw_vec_t;

  ev_t exp_q[$];
  ev_t obs;
  ev_t exp_e;
  int  cyc = 0;
  int  t0 = 0;
  int  checks = 0;
  int  failures = 0;
  logic [9:0] cur_sw;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe cycle must match the next queued event.
  always @(negedge clk) begin
    if (sw_changed || (|key_press) || (|key_release) || (|key_repeat)) begin
      obs.rel    = cyc - t0;
      obs.sw_chg = sw_changed;
      obs.sw     = sw_stable;
      obs.lvl    = key_level;
      obs.press  = key_press;
      obs.rls    = key_release;
      obs.rpt    = key_repeat;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual: rel=%0d sw_chg=%b sw=%h lvl=%b press=%b rls=%b rpt=%b required: no event",
                 obs.rel, obs.sw_chg, obs.sw, obs.lvl, obs.press, obs.rls, obs.rpt);
      end else begin
        exp_e = exp_q.pop_front();
        if (obs !== exp_e) begin
          failures++;
          $display("FAIL event actual: rel=%0d sw_chg=%b sw=%h lvl=%b press=%b rls=%b rpt=%b required: rel=%0d sw_chg=%b sw=%h lvl=%b press=%b rls=%b rpt=%b",
                   obs.rel, obs.sw_chg, obs.sw, obs.lvl, obs.press, obs.rls, obs.rpt,
                   exp_e.rel, exp_e.sw_chg, exp_e.sw, exp_e.lvl, exp_e.press, exp_e.rls, exp_e.rpt);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic mark();
    t0 = cyc;
  endtask

  task automatic push(input int rel, input logic sc, input logic [9:0] sw,
                      input logic [2:0] lvl, input logic [2:0] press,
                      input logic [2:0] rls, input logic [2:0] rpt);
    ev_t e;
    e.rel = rel; e.sw_chg = sc; e.sw = sw; e.lvl = lvl;
    e.press = press; e.rls = rls; e.rpt = rpt;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_events actual=%0d required=0 (next rel=%0d)",
               name, exp_q.size(), exp_q[0].rel);
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    check_val({name, "_sw_stable"},  32'(sw_stable),   32'h0);
    check_val({name, "_sw_changed"}, 32'(sw_changed),  32'h0);
    check_val({name, "_key_level"},  32'(key_level),   32'h0);
    check_val({name, "_strobes"},    32'({key_press, key_release, key_repeat}), 32'h0);
  endtask

  sw_vec_t sw_tab [4];

  initial begin
    sw_tab[0] = '{sw_in: 10'h15A, sw_exp: 10'h15A};
    sw_tab[1] = '{sw_in: 10'h3FF, sw_exp: 10'h3FF};
    sw_tab[2] = '{sw_in: 10'h000, sw_exp: 10'h000};
    sw_tab[3] = '{sw_in: 10'h001, sw_exp: 10'h001};

    rst_n       = 1'b0;
    sw_async    = 10'h2A5;
    key_n_async = 3'b111;
    cur_sw      = 10'h2A5;
    run(3);
    check_all_zero("reset");

    // Reset release with switches already up: one accepted change on edge 7.
    mark();
    rst_n = 1'b1;
    push(7, 1'b1, 10'h2A5, 3'b000, 3'b000, 3'b000, 3'b000);
    run(12);
    check_drained("reset_release_sw");
    check_val("sw_after_reset", 32'(sw_stable), 32'h2A5);

    // Switch vector table: all bits of each change land as one event.
    for (int i = 0; i < 4; i++) begin
      mark();
      sw_async = sw_tab[i].sw_in;
      cur_sw   = sw_tab[i].sw_exp;
      push(7, 1'b1, sw_tab[i].sw_exp, 3'b000, 3'b000, 3'b000, 3'b000);
      run(12);
      check_val("sw_table_level", 32'(sw_stable), 32'(sw_tab[i].sw_exp));
      check_drained("sw_table");
    end

    // Three-cycle switch glitch is rejected.
    mark();
    sw_async = 10'h003;
    run(3);
    sw_async = cur_sw;
    run(12);
    check_val("sw_glitch_level", 32'(sw_stable), 32'(cur_sw));
    check_drained("sw_glitch");

    // KEY_N[1] low for three cycles only.
    mark();
    key_n_async = 3'b101;
    run(3);
    key_n_async = 3'b111;
    run(15);
    check_val("key1_glitch_level", 32'(key_level), 32'h0);
    check_drained("key1_glitch");

    // KEY_N[0] held 40 cycles: press, six repeats, release wins over the repeat due at 47.
    mark();
    key_n_async = 3'b110;
    push(7, 1'b0, cur_sw, 3'b001, 3'b001, 3'b000, 3'b000);
    for (int r = 17; r <= 42; r += 5)
      push(r, 1'b0, cur_sw, 3'b001, 3'b000, 3'b000, 3'b001);
    push(47, 1'b0, cur_sw, 3'b000, 3'b000, 3'b001, 3'b000);
    run(40);
    check_val("key0_level_held", 32'(key_level), 32'h1);
    key_n_async = 3'b111;
    run(15);
    check_drained("key0_hold");
    check_val("key0_level_released", 32'(key_level), 32'h0);

    // KEY_N[0] bouncing every 2 cycles, then settling low at rel 20.
    mark();
    for (int b = 0; b < 5; b++) begin
      key_n_async = 3'b110;
      run(2);
      key_n_async = 3'b111;
      run(2);
    end
    key_n_async = 3'b110;
    push(27, 1'b0, cur_sw, 3'b001, 3'b001, 3'b000, 3'b000);
    push(35, 1'b0, cur_sw, 3'b000, 3'b000, 3'b001, 3'b000);
    run(8);
    key_n_async = 3'b111;
    run(15);
    check_drained("key0_bounce");

    // All three keys together: coincident press, repeats and release.
    mark();
    key_n_async = 3'b000;
    push(7,  1'b0, cur_sw, 3'b111, 3'b111, 3'b000, 3'b000);
    push(17, 1'b0, cur_sw, 3'b111, 3'b000, 3'b000, 3'b111);
    push(22, 1'b0, cur_sw, 3'b111, 3'b000, 3'b000, 3'b111);
    push(27, 1'b0, cur_sw, 3'b000, 3'b000, 3'b111, 3'b000);
    run(20);
    key_n_async = 3'b111;
    run(15);
    check_drained("all_keys");

    // Reset while key 2 repeats: async clear, no release, fresh press afterwards.
    mark();
    key_n_async = 3'b011;
    push(7,  1'b0, cur_sw, 3'b100, 3'b100, 3'b000, 3'b000);
    push(17, 1'b0, cur_sw, 3'b100, 3'b000, 3'b000, 3'b100);
    run(20);
    check_val("key2_level_before_reset", 32'(key_level), 32'h4);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    run(3);
    check_drained("pre_reset_events");
    mark();
    rst_n = 1'b1;
    push(7, 1'b1, cur_sw, 3'b100, 3'b100, 3'b000, 3'b000);
    run(12);
    check_drained("post_reset_press");
    check_val("key2_level_after_reset", 32'(key_level), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/de1soc_input_conditioner.md
Name: de1soc_input_conditioner

Overview:
- Board-side receiver for the DE1-SoC slide switches and push-buttons, i.e. the signals the onboard bench drives into the top-level.
- Synchronises the asynchronous SW and KEY_N pins to clk, debounces them, and produces clean levels, single-cycle press/release strobes and auto-repeat strobes for the core logic.
- Sits directly behind the board pins inside de1soc_onboard. KEY_N[3] stays the board reset source and is not handled here.

Parameters:
- N_SW, 10, number of slide switches.
- N_KEY, 3, number of push-buttons handled (KEY_N[2:0]).
- DEBOUNCE_CYCLES, 500000, cycles an input must stay stable before being accepted (10 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000, cycles from an accepted press to the first repeat strobe; minimum 2.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes; minimum 2.

Ports:
- clk  in  1  board clock (50 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- sw_async  in  N_SW  raw switch pins, 1 = up.
- key_n_async  in  N_KEY  raw button pins, active-low (0 = pressed).
- sw_stable  out  N_SW  debounced switch vector.
- sw_changed  out  1  one-cycle strobe when sw_stable updates.
- key_level  out  N_KEY  debounced button state, active-high (1 = held).
- key_press  out  N_KEY  one-cycle strobe per accepted press.
- key_release  out  N_KEY  one-cycle strobe per accepted release.
- key_repeat  out  N_KEY  one-cycle auto-repeat strobe while held.

Behaviour:
- Reset:
  - Asynchronous, active-low; all state is cleared immediately on assertion.
  - Synchroniser flops reset to the idle pin level (sw 0, key_n 1).
  - sw_stable=0, sw_changed=0, key_level=0, and all strobes are 0.
  - Debounce and repeat counters are 0; every key FSM is in IDLE.
  - No strobe is asserted in the first cycle after release of reset.
  - Reset mid-press or mid-repeat cancels everything; no release strobe is emitted.
- Synchroniser: 2-flop chain per bit. Key bits are inverted after the chain, so internal levels are active-high.
- Debounce, per group (the whole switch vector is one group; each key is its own 1-bit group):
  - Registers: cand (candidate value) and cnt (counter).
  - If sync != cand: cand <= sync, cnt <= 0.
  - Else if cand != stable:
    - If cnt == DEBOUNCE_CYCLES-1: stable <= cand, cnt <= 0, and the change strobe asserts in the same cycle as the new stable value.
    - Otherwise cnt <= cnt+1.
  - Else cnt holds at 0.
- Latency: a clean input change made before rising edge E0 appears on the output after edge E0+DEBOUNCE_CYCLES+2. With DEBOUNCE_CYCLES=4 that is 7 edges.
- Glitch rejection: any glitch at the synchroniser output shorter than DEBOUNCE_CYCLES cycles produces no output change and no strobe. A bounce restarts the count.
- Simultaneous switch changes are one event (a single sw_changed). Keys are fully independent; simultaneous strobes on different keys are legal.
- Key FSM, one per key, states IDLE, HOLD, REPEAT, with a repeat counter rcnt:
  - IDLE: on debounced rise -> HOLD, key_press=1, rcnt=0.
  - HOLD: rcnt increments; at rcnt == REPEAT_DELAY-1 -> REPEAT, key_repeat=1, rcnt=0.
  - REPEAT: rcnt increments; at rcnt == REPEAT_PERIOD-1 -> key_repeat=1, rcnt=0, stay in REPEAT.
  - HOLD or REPEAT: on debounced fall -> IDLE, key_release=1. Release takes priority over a repeat due in the same cycle.
  - key_level equals the debounced state; key_press and key_level rise in the same cycle.
- Counter widths are $clog2 of the relevant parameter; counters never wrap, because they are cleared on reaching their terminal value.

Decomposition:
- Package de1soc_io_pkg:
  - key_state_t enum {IDLE, HOLD, REPEAT};
  - default timing constants (CLK_HZ=50_000_000, DEBOUNCE_MS=10, REPEAT_DELAY_MS=500, REPEAT_PERIOD_MS=100).
- Sub-module input_debounce:
  - Parameters W, DEBOUNCE_CYCLES, RESET_VAL.
  - Contains the synchroniser, cand/cnt logic, stable output and change strobe.
  - Instantiated once with W=N_SW, and N_KEY times with W=1.
  - Repeat FSMs live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Reset release with sw_async=0x2A5, key_n_async=3'b111 -> sw_stable goes 0 -> 0x2A5 after the 7th edge, with exactly one sw_changed strobe. All key outputs stay 0.
- KEY_N[1] driven low for 3 cycles, then high -> no change on key_level, key_press or key_release.
- KEY_N[0] held low for 40 cycles:
  - key_press[0] at edge 7.
  - key_repeat[0] at edges 17, 22, 27, 32, 37, 42.
  - Release then gives key_release[0] 7 edges after the rising pin.
- KEY_N[0] bounces 0/1 every 2 cycles for 20 cycles, then holds 0 -> exactly one key_press[0], 7 edges after the final settle.
- All three keys pressed on the same cycle -> key_press=3'b111 in a single cycle; the repeats coincide on all three keys.
- rst_n pulsed low while key 2 is in REPEAT -> all outputs drop to 0 asynchronously with no release strobe. With the pin still held after reset, a new key_press[2] follows 7 edges after reset deassertion.
